// File: rtl/sprite_animator.sv
// Frame sequencer: FRAMES x 8-row sprite memory, stepped by sw rising edge or auto timer.
// Latency: sw seen high at edge E -> frame_idx at E+1, rows and frame_strobe at E+2; no backpressure.
module sprite_animator #(
  parameter int WIDTH    = 8,
  parameter int FRAMES   = 4,
  parameter int TICK_DIV = 25_000_000,
  parameter int FW       = $clog2(FRAMES)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sw,
  input  logic             auto_en,
  input  logic             dir,
  input  logic             hold,
  input  logic             wr_en,
  input  logic [FW-1:0]    wr_frame,
  input  logic [2:0]       wr_row,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] data0,
  output logic [WIDTH-1:0] data1,
  output logic [WIDTH-1:0] data2,
  output logic [WIDTH-1:0] data3,
  output logic [WIDTH-1:0] data4,
  output logic [WIDTH-1:0] data5,
  output logic [WIDTH-1:0] data6,
  output logic [WIDTH-1:0] data7,
  output logic [FW-1:0]    frame_idx,
  output logic             frame_strobe
);

  localparam int TW = $clog2(TICK_DIV);
  localparam logic [FW-1:0] LAST_IDX = FW'(FRAMES - 1);
  localparam logic [TW-1:0] TCNT_END = TW'(TICK_DIV - 1);

  logic [WIDTH-1:0] mem  [FRAMES][8];
  logic [WIDTH-1:0] rows [8];
  logic [TW-1:0]    tcnt;
  logic             sw_s;
  logic             sw_prev;
  logic             adv_q;
  logic             step;
  logic             tick;
  logic             advance;
  logic [FW-1:0]    idx_next;

  assign step    = sw_s & ~sw_prev;
  assign tick    = auto_en & ~hold & (tcnt == TCNT_END);
  assign advance = (step | tick) & ~hold;

  // Explicit wrap compares keep non-power-of-two frame counts in range.
  always_comb begin
    idx_next = frame_idx;
    if (advance) begin
      if (dir) idx_next = (frame_idx == '0) ? LAST_IDX : frame_idx - 1'b1;
      else     idx_next = (frame_idx == LAST_IDX) ? '0 : frame_idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      // Edge history reset high so a switch held through reset is not a step.
      sw_s         <= 1'b1;
      sw_prev      <= 1'b1;
      tcnt         <= '0;
      frame_idx    <= '0;
      adv_q        <= 1'b0;
      frame_strobe <= 1'b0;
      for (int r = 0; r < 8; r++) begin
        rows[r] <= '0;
        for (int f = 0; f < FRAMES; f++) mem[f][r] <= '0;
      end
    end else begin
      sw_s    <= sw;
      sw_prev <= sw_s;
      if (!auto_en)  tcnt <= '0;
      else if (!hold) tcnt <= (tcnt == TCNT_END) ? '0 : tcnt + 1'b1;
      frame_idx    <= idx_next;
      adv_q        <= advance;
      frame_strobe <= adv_q;
      for (int r = 0; r < 8; r++) rows[r] <= mem[frame_idx][r];
      if (wr_en && (int'(wr_frame) < FRAMES)) mem[wr_frame][wr_row] <= wr_data;
    end
  end

  assign data0 = rows[0];
  assign data1 = rows[1];
  assign data2 = rows[2];
  assign data3 = rows[3];
  assign data4 = rows[4];
  assign data5 = rows[5];
  assign data6 = rows[6];
  assign data7 = rows[7];

endmodule

// File: tb/tb_sprite_animator.sv
// Bench: two animators (4 frames / tick 4, 3 frames / tick 5) on shared stimulus vs a reference model.
module tb_sprite_animator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1, sw = 1'b0, auto_en = 1'b0, dir = 1'b0, hold = 1'b0, wr_en = 1'b0;
  logic [1:0] wr_frame = '0;
  logic [2:0] wr_row = '0;
  logic [7:0] wr_data = '0;
  logic [7:0] dd [2][8];
  logic [1:0] di [2];
  logic       ds [2];

  sprite_animator #(.WIDTH(8), .FRAMES(4), .TICK_DIV(4)) dut_a (
    .clk(clk), .reset(reset), .sw(sw), .auto_en(auto_en), .dir(dir), .hold(hold),
    .wr_en(wr_en), .wr_frame(wr_frame), .wr_row(wr_row), .wr_data(wr_data),
    .data0(dd[0][0]), .data1(dd[0][1]), .data2(dd[0][2]), .data3(dd[0][3]),
    .data4(dd[0][4]), .data5(dd[0][5]), .data6(dd[0][6]), .data7(dd[0][7]),
    .frame_idx(di[0]), .frame_strobe(ds[0]));

  sprite_animator #(.WIDTH(8), .FRAMES(3), .TICK_DIV(5)) dut_b (
    .clk(clk), .reset(reset), .sw(sw), .auto_en(auto_en), .dir(dir), .hold(hold),
    .wr_en(wr_en), .wr_frame(wr_frame), .wr_row(wr_row), .wr_data(wr_data),
    .data0(dd[1][0]), .data1(dd[1][1]), .data2(dd[1][2]), .data3(dd[1][3]),
    .data4(dd[1][4]), .data5(dd[1][5]), .data6(dd[1][6]), .data7(dd[1][7]),
    .frame_idx(di[1]), .frame_strobe(ds[1]));

  int checks = 0;
  int errors = 0;

  function automatic int nfr(input int k);
    return (k == 0) ? 4 : 3;
  endfunction
  function automatic int tdv(input int k);
    return (k == 0) ? 4 : 5;
  endfunction

  // Reference model. A step is sw sampled low then high on the two previous edges;
  // the displayed rows follow the index one edge later, the strobe follows the advance one edge later.
  int         m_idx [2];
  int         m_cnt [2];
  logic [7:0] m_data [2][8];
  logic [7:0] m_mem [2][4][8];
  logic       m_stb [2];
  logic       m_advp [2];
  logic       sw1, sw2;

  always @(posedge clk) begin : model
    logic step;
    step = sw1 && !sw2;
    for (int k = 0; k < 2; k++) begin : inst
      logic tick, adv;
      if (reset) begin
        m_idx[k] = 0; m_cnt[k] = 0; m_stb[k] = 1'b0; m_advp[k] = 1'b0;
        for (int r = 0; r < 8; r++) begin
          m_data[k][r] = 8'h00;
          for (int f = 0; f < 4; f++) m_mem[k][f][r] = 8'h00;
        end
      end else begin
        tick = auto_en && !hold && (m_cnt[k] == tdv(k) - 1);
        adv  = (step || tick) && !hold;
        for (int r = 0; r < 8; r++) m_data[k][r] = m_mem[k][m_idx[k]][r];
        m_stb[k]  = m_advp[k];
        m_advp[k] = adv;
        if (!auto_en) m_cnt[k] = 0;
        else if (!hold) m_cnt[k] = (m_cnt[k] + 1) % tdv(k);
        if (adv) m_idx[k] = dir ? (m_idx[k] + nfr(k) - 1) % nfr(k) : (m_idx[k] + 1) % nfr(k);
        if (wr_en && int'(wr_frame) < nfr(k)) m_mem[k][wr_frame][wr_row] = wr_data;
      end
    end
    if (reset) begin sw1 = 1'b1; sw2 = 1'b1; end
    else begin sw2 = sw1; sw1 = sw; end
  end

  task automatic pulse();
    sw = 1'b1;
    repeat (2) @(negedge clk);
    sw = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; sw = 1'b1; wr_en = 1'b1; wr_frame = 2'd0; wr_row = 3'd0; wr_data = 8'hff;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (di[k] !== 2'd0 || ds[k] !== 1'b0) begin
        errors++; $display("FAIL reset_ctl[%0d] idx %0d strobe %0b, want 0 0", k, di[k], ds[k]);
      end
      for (int r = 0; r < 8; r++) begin
        checks++;
        if (dd[k][r] !== 8'h00) begin
          errors++; $display("FAIL reset_data[%0d][%0d] got %h want 00", k, r, dd[k][r]);
        end
      end
    end
    wr_en = 1'b0; reset = 1'b0;
    repeat (4) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (di[k] !== 2'd0) begin
        errors++; $display("FAIL reset_sw_held[%0d] idx %0d want 0", k, di[k]);
      end
    end
  endtask

  task automatic test_load();
    for (int f = 0; f < 4; f++) begin
      for (int r = 0; r < 8; r++) begin
        wr_en = 1'b1; wr_frame = 2'(f); wr_row = 3'(r); wr_data = 8'(16 * (f + 1) + r);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
          checks++;
          if (di[k] !== 2'(m_idx[k]) || dd[k][r] !== m_data[k][r]) begin
            errors++; $display("FAIL load[%0d] idx %0d row%0d %h, model %0d %h", k, di[k], r, dd[k][r], m_idx[k], m_data[k][r]);
          end
        end
      end
    end
    wr_en = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (dd[0][3] !== 8'h13 || di[0] !== 2'd0) begin
      errors++; $display("FAIL load_data3 got %h idx %0d want 13 idx 0", dd[0][3], di[0]);
    end
    checks++;
    if (dd[1][7] !== 8'h17) begin
      errors++; $display("FAIL load_data7_b got %h want 17", dd[1][7]);
    end
  endtask

  task automatic test_forward();
    int stb, chg;
    logic [1:0] prev;
    dir = 1'b0; sw = 1'b0;
    repeat (3) @(negedge clk);
    for (int p = 0; p < 5; p++) begin
      stb = 0;
      for (int c = 0; c < 5; c++) begin
        sw = (c < 2);
        @(negedge clk);
        if (ds[0] === 1'b1) stb++;
      end
      checks++;
      if (di[0] !== 2'((p + 1) % 4)) begin
        errors++; $display("FAIL fwd_idx pulse %0d got %0d want %0d", p, di[0], (p + 1) % 4);
      end
      checks++;
      if (stb != 1) begin
        errors++; $display("FAIL fwd_strobe pulse %0d got %0d pulses want 1", p, stb);
      end
    end
    checks++;
    if (di[1] !== 2'd2 || dd[1][0] !== 8'h30) begin
      errors++; $display("FAIL fwd_b idx %0d data0 %h want 2 30", di[1], dd[1][0]);
    end
    chg = 0; prev = di[0];
    for (int c = 0; c < 20; c++) begin
      sw = 1'b1;
      @(negedge clk);
      if (di[0] !== prev) chg++;
      prev = di[0];
    end
    sw = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (chg != 1 || di[0] !== 2'd2) begin
      errors++; $display("FAIL fwd_held changes %0d idx %0d want 1 change idx 2", chg, di[0]);
    end
  endtask

  task automatic test_backward();
    dir = 1'b0;
    for (int p = 0; p < 4 && di[0] !== 2'd0; p++) pulse();
    checks++;
    if (di[0] !== 2'd0) begin
      errors++; $display("FAIL bwd_setup idx %0d want 0", di[0]);
    end
    dir = 1'b1;
    pulse();
    checks++;
    if (di[0] !== 2'd3 || dd[0][0] !== 8'h40) begin
      errors++; $display("FAIL bwd_wrap idx %0d data0 %h want 3 40", di[0], dd[0][0]);
    end
    checks++;
    if (di[1] !== 2'(m_idx[1]) || dd[1][0] !== m_data[1][0]) begin
      errors++; $display("FAIL bwd_b idx %0d data0 %h, model %0d %h", di[1], dd[1][0], m_idx[1], m_data[1][0]);
    end
    dir = 1'b0;
  endtask

  task automatic test_auto();
    sw = 1'b0; hold = 1'b0; dir = 1'b0; auto_en = 1'b0;
    repeat (3) @(negedge clk);
    auto_en = 1'b1;
    for (int n = 1; n <= 24; n++) begin
      sw = (n == 19 || n == 20);
      @(negedge clk);
      checks++;
      if (di[0] !== 2'((3 + n / 4) % 4)) begin
        errors++; $display("FAIL auto_idx cycle %0d got %0d want %0d", n, di[0], (3 + n / 4) % 4);
      end
      checks++;
      if (di[1] !== 2'(m_idx[1])) begin
        errors++; $display("FAIL auto_idx_b cycle %0d got %0d model %0d", n, di[1], m_idx[1]);
      end
    end
  endtask

  task automatic test_hold();
    sw = 1'b0;
    repeat (2) @(negedge clk);
    hold = 1'b1;
    for (int i = 0; i < 12; i++) begin
      sw = (i < 9) && (i % 2 == 1);
      @(negedge clk);
      checks++;
      if (di[0] !== 2'd1 || ds[0] !== 1'b0) begin
        errors++; $display("FAIL hold_frozen cycle %0d idx %0d strobe %0b want 1 0", i, di[0], ds[0]);
      end
    end
    sw = 1'b0; hold = 1'b0;
    @(negedge clk);
    checks++;
    if (di[0] !== 2'd1) begin
      errors++; $display("FAIL hold_resume1 idx %0d want 1", di[0]);
    end
    @(negedge clk);
    checks++;
    if (di[0] !== 2'd2) begin
      errors++; $display("FAIL hold_resume2 idx %0d want 2", di[0]);
    end
    checks++;
    if (di[1] !== 2'(m_idx[1])) begin
      errors++; $display("FAIL hold_b idx %0d model %0d", di[1], m_idx[1]);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 2) == 0) sw = ~sw;
      if ($urandom_range(0, 15) == 0) dir = ~dir;
      auto_en  = ($urandom_range(0, 7) != 0);
      hold     = ($urandom_range(0, 5) == 0);
      wr_en    = ($urandom_range(0, 3) == 0);
      wr_frame = 2'($urandom_range(0, 3));
      wr_row   = 3'($urandom_range(0, 7));
      wr_data  = 8'($urandom);
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (di[k] !== 2'(m_idx[k]) || ds[k] !== m_stb[k] || int'(di[k]) >= nfr(k)) begin
          errors++; $display("FAIL rand_ctl[%0d] cycle %0d idx %0d strobe %0b, model %0d %0b", k, c, di[k], ds[k], m_idx[k], m_stb[k]);
        end
        for (int r = 0; r < 8; r++) begin
          checks++;
          if (dd[k][r] !== m_data[k][r]) begin
            errors++; $display("FAIL rand_data[%0d][%0d] cycle %0d got %h model %h", k, r, c, dd[k][r], m_data[k][r]);
          end
        end
      end
    end
    wr_en = 1'b0; hold = 1'b0; sw = 1'b0; dir = 1'b0; auto_en = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    for (int p = 0; p < 4 && di[1] === 2'd0; p++) pulse();
    checks++;
    if (di[1] === 2'd0) begin
      errors++; $display("FAIL mid_setup idx_b %0d want nonzero", di[1]);
    end
    auto_en = 1'b1; sw = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b1; wr_en = 1'b1; wr_frame = 2'd0; wr_row = 3'd0; wr_data = 8'hff; dir = 1'b1;
    @(negedge clk);
    reset = 1'b0; wr_en = 1'b0; auto_en = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (di[k] !== 2'd0 || ds[k] !== 1'b0 || dd[k][0] !== 8'h00 || dd[k][7] !== 8'h00) begin
          errors++; $display("FAIL mid_reset[%0d] cycle %0d idx %0d strobe %0b d0 %h d7 %h want 0 0 00 00", k, c, di[k], ds[k], dd[k][0], dd[k][7]);
        end
      end
    end
    sw = 1'b0;
  endtask

  initial begin
    test_reset();
    test_load();
    test_forward();
    test_backward();
    test_auto();
    test_hold();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
